// File: rtl/sram_bist_pkg.sv
// Shared types and helpers for the SRAM BIST master.
// FSM encodings, test phase and expected-pattern function.
package sram_bist_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_IDLE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    typedef enum logic {
        PH_WRITE = 1'b0,
        PH_READ  = 1'b1
    } phase_e;

    // Pattern is address xor seed, inverted on the second pass.
    function automatic logic [31:0] exp_data(
        input logic [31:0] addr,
        input logic [31:0] seed,
        input logic        inv
    );
        return (addr ^ seed) ^ {32{inv}};
    endfunction

endpackage

// File: rtl/sram_bist_if.sv
// User-port bundle between the BIST master and the SRAM controller.
// Master drives requests, slave returns busy / read data.
interface sram_bist_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              start_o;
    logic              rw_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              busy_i;
    logic              data_ready_i;
    logic [DATA_W-1:0] rdata_i;

    modport master (
        output start_o, rw_o, addr_o, wdata_o,
        input  busy_i, data_ready_i, rdata_i
    );

    modport slave (
        input  start_o, rw_o, addr_o, wdata_o,
        output busy_i, data_ready_i, rdata_i
    );
endinterface

// File: rtl/sram_bist_checker.sv
// Read-back comparison and error bookkeeping for the BIST.
// Error counter saturates; first failure is captured once.
module sram_bist_checker #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8,
    parameter int ERRCNT_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                cmp_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [DATA_W-1:0]   exp,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data
);
    logic [ERRCNT_W-1:0] err_q, err_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;

    // Count mismatches; an empty counter marks the first one.
    always_comb begin
        err_d   = err_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        if (clr) begin
            err_d   = '0;
            faddr_d = '0;
            fdata_d = '0;
        end else if (cmp_en && (rdata != exp)) begin
            if (err_q != '1) begin
                err_d = err_q + ERRCNT_W'(1);
            end
            if (err_q == '0) begin
                faddr_d = addr;
                fdata_d = rdata;
            end
        end
    end

    // Error state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= '0;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            err_q   <= err_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    end

    assign err_count      = err_q;
    assign first_err_addr = faddr_q;
    assign first_err_data = fdata_q;
endmodule

// File: rtl/sram_bist_master.sv
// Two-pass write/read-back SRAM self test driving the controller
// user port; reports pass, error summary and handshake timeout.
module sram_bist_master
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 2**19-1,
    parameter int TIMEOUT   = 15,
    parameter int ERRCNT_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [DATA_W-1:0]   seed,
    sram_bist_if.master         bus,
    output logic                running,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    output logic                timeout_err
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              pass_q, pass_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              clr;
    logic              cmp_en;
    logic              accept;
    logic [DATA_W-1:0] exp_cur;

    assign exp_cur = DATA_W'(exp_data(32'(addr_q), 32'(seed_q), pass_q));
    assign accept  = bus.busy_i && (phase_q == PH_WRITE || bus.data_ready_i);

    // Sequencer: issue one op, wait for busy, wait for idle, advance.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        addr_d    = addr_q;
        seed_d    = seed_q;
        pass_d    = pass_q;
        to_cnt_d  = to_cnt_q;
        running_d = running_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        clr       = 1'b0;
        cmp_en    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    seed_d    = seed;
                    clr       = 1'b1;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                    phase_d   = PH_WRITE;
                    addr_d    = '0;
                    running_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (accept) begin
                    cmp_en  = (phase_q == PH_READ);
                    state_d = S_WAIT_IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (!bus.busy_i) begin
                    state_d = S_ISSUE;
                    if (addr_q != ADDR_W'(LAST_ADDR)) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else if (phase_q == PH_WRITE) begin
                        phase_d = PH_READ;
                        addr_d  = '0;
                    end else if (!pass_q) begin
                        pass_d  = 1'b1;
                        phase_d = PH_WRITE;
                        addr_d  = '0;
                    end else begin
                        running_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_WRITE;
            addr_q    <= '0;
            seed_q    <= '0;
            pass_q    <= 1'b0;
            to_cnt_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            seed_q    <= seed_d;
            pass_q    <= pass_d;
            to_cnt_q  <= to_cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    sram_bist_checker #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .ERRCNT_W (ERRCNT_W)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .cmp_en         (cmp_en),
        .addr           (addr_q),
        .rdata          (bus.rdata_i),
        .exp            (exp_cur),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    assign bus.start_o  = (state_q == S_ISSUE);
    assign bus.rw_o     = (phase_q == PH_READ);
    assign bus.addr_o   = addr_q;
    assign bus.wdata_o  = exp_cur;
    assign running      = running_q;
    assign done         = done_q;
    assign timeout_err  = timeout_q;
    assign pass         = done_q && (err_count == '0) && !timeout_q;
endmodule
